// File: rtl/dram_resp.sv
// dram_resp: synthesizable memory-side responder for DRAM request ports.
//
// Purpose:
//   Serves one read and one write request per cycle from an internal word
//   array. Reads return through a fixed RD_LAT-stage pipeline, flagged by
//   dram_valid. Writes commit at the clock edge. Out-of-range accesses set a
//   sticky err flag. Reads return 0 for these accesses, and writes are dropped.
//
// Optional feature (macro DRAM_RESP_FWD_EN):
//   When defined, in-range writes are forwarded into every in-flight read that
//   targets the same address. This includes a read that is being loaded on the
//   same edge. Returned data then reflects all writes issued while the read was
//   in flight. When undefined, a read returns the array snapshot taken when it
//   was issued.
//
// Ports:
//   clk         in   1           clock, rising edge
//   srstn       in   1           asynchronous active-low reset
//   dram_en_rd  in   1           read request
//   addr_in     in   ADDR_WIDTH  read word address
//   dram_en_wr  in   1           write request
//   addr_out    in   ADDR_WIDTH  write word address
//   data_wr     in   DATA_WIDTH  write data
//   data_rd     out  DATA_WIDTH  returned read data (0 when not valid)
//   dram_valid  out  1           data_rd carries a returned read word
//   err         out  1           sticky out-of-range flag
//   rd_cnt      out  32          accepted read requests (wrapping)
//   wr_cnt      out  32          accepted write requests (wrapping)
module dram_resp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18,
   parameter int MEM_DEPTH  = 1024,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  dram_en_rd,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  dram_en_wr,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [DATA_WIDTH-1:0] data_wr,
   output logic [DATA_WIDTH-1:0] data_rd,
   output logic                  dram_valid,
   output logic                  err,
   output logic [31:0]           rd_cnt,
   output logic [31:0]           wr_cnt
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic                  r_vld  [RD_LAT];
   logic [DATA_WIDTH-1:0] r_data [RD_LAT];
   logic                  r_err;
   logic [31:0]           r_rd_cnt;
   logic [31:0]           r_wr_cnt;

   logic                  w_rd_inr;
   logic                  w_wr_inr;
   logic                  w_wr_ok;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [DATA_WIDTH-1:0] w_data_nxt [RD_LAT];

   assign w_rd_inr = (32'(addr_in)  < MEM_DEPTH);
   assign w_wr_inr = (32'(addr_out) < MEM_DEPTH);
   assign w_wr_ok  = dram_en_wr & w_wr_inr;
   assign w_rd_idx = addr_in[IDX_W-1:0];
   assign w_wr_idx = addr_out[IDX_W-1:0];

`ifdef DRAM_RESP_FWD_EN
   // Entry addresses are tracked only for forwarding address matches.
   logic [ADDR_WIDTH-1:0] r_addr [RD_LAT];

   always_ff @(posedge clk) begin
      r_addr[0] <= addr_in;
      for (int k = 1; k < RD_LAT; k++) begin
         r_addr[k] <= r_addr[k-1];
      end
   end
`endif

   // Next data for each stage.
   // Stage 0 captures the pre-write array word, or 0 when out of range.
   always_comb begin
      w_data_nxt[0] = w_rd_inr ? r_mem[w_rd_idx] : '0;
      for (int k = 1; k < RD_LAT; k++) begin
         w_data_nxt[k] = r_data[k-1];
      end
`ifdef DRAM_RESP_FWD_EN
      // An out-of-range read address can never equal an in-range write
      // address, so out-of-range reads keep their 0 data.
      if (w_wr_ok) begin
         if (dram_en_rd && (addr_in == addr_out)) begin
            w_data_nxt[0] = data_wr;
         end
         for (int k = 1; k < RD_LAT; k++) begin
            if (r_vld[k-1] && (r_addr[k-1] == addr_out)) begin
               w_data_nxt[k] = data_wr;
            end
         end
      end
`endif
   end

   // Array and pipeline data: no reset; validity is carried by r_vld.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[w_wr_idx] <= data_wr;
      end
      for (int k = 0; k < RD_LAT; k++) begin
         r_data[k] <= w_data_nxt[k];
      end
   end

   // Control state: valids, sticky error, request counters.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         for (int k = 0; k < RD_LAT; k++) begin
            r_vld[k] <= 1'b0;
         end
         r_err    <= 1'b0;
         r_rd_cnt <= 32'd0;
         r_wr_cnt <= 32'd0;
      end else begin
         r_vld[0] <= dram_en_rd;
         for (int k = 1; k < RD_LAT; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
         if ((dram_en_rd && !w_rd_inr) || (dram_en_wr && !w_wr_inr)) begin
            r_err <= 1'b1;
         end
         if (dram_en_rd) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
         if (dram_en_wr) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
      end
   end

   assign dram_valid = r_vld[RD_LAT-1];
   assign data_rd    = r_vld[RD_LAT-1] ? r_data[RD_LAT-1] : '0;
   assign err        = r_err;
   assign rd_cnt     = r_rd_cnt;
   assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_dram_resp.sv
// Directed testbench for dram_resp (default parameters, RD_LAT = 2).
// Inputs change right after a falling edge. Outputs are checked on falling
// edges.
module tb_dram_resp;

   logic        clk;
   logic        srstn;
   logic        dram_en_rd;
   logic [17:0] addr_in;
   logic        dram_en_wr;
   logic [17:0] addr_out;
   logic [31:0] data_wr;
   logic [31:0] data_rd;
   logic        dram_valid;
   logic        err;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   int n_chk = 0;
   int n_err = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   dram_resp dut (
      .clk        (clk),
      .srstn      (srstn),
      .dram_en_rd (dram_en_rd),
      .addr_in    (addr_in),
      .dram_en_wr (dram_en_wr),
      .addr_out   (addr_out),
      .data_wr    (data_wr),
      .data_rd    (data_rd),
      .dram_valid (dram_valid),
      .err        (err),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Apply one cycle of requests.
   // The inputs are sampled on the next rising edge.
   // The task returns at the following falling edge.
   task automatic drive(input logic rd, input logic [17:0] ra,
                        input logic wr, input logic [17:0] wa, input logic [31:0] wd);
      dram_en_rd = rd;
      addr_in    = ra;
      dram_en_wr = wr;
      addr_out   = wa;
      data_wr    = wd;
      if (rd) exp_rd++;
      if (wr) exp_wr++;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 18'd0, 1'b0, 18'd0, 32'd0);
   endtask

   task automatic wr(input logic [17:0] a, input logic [31:0] d);
      drive(1'b0, 18'd0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [17:0] a);
      drive(1'b1, a, 1'b0, 18'd0, 32'd0);
   endtask

   logic [31:0] exp_coll;
   logic [31:0] exp_rmw;

   initial begin
`ifdef DRAM_RESP_FWD_EN
      exp_coll = 32'h0000_000B;
      exp_rmw  = 32'h0000_0020;
`else
      exp_coll = 32'h0000_000A;
      exp_rmw  = 32'h0000_0010;
`endif
      srstn = 1'b0;
      dram_en_rd = 1'b0; addr_in = '0;
      dram_en_wr = 1'b0; addr_out = '0; data_wr = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_valid", 32'(dram_valid), 32'd0);
      check("rst_data", data_rd, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdcnt", rd_cnt, 32'd0);
      check("rst_wrcnt", wr_cnt, 32'd0);
      srstn = 1'b1;

      // Basic: write 5, then read 5 two cycles later
      wr(18'd5, 32'h0000_1234);
      idle();
      rd(18'd5);
      check("basic_early", 32'(dram_valid), 32'd0);
      idle();
      check("basic_valid", 32'(dram_valid), 32'd1);
      check("basic_data", data_rd, 32'h0000_1234);
      check("basic_rdcnt", rd_cnt, 32'(exp_rd));
      check("basic_wrcnt", wr_cnt, 32'(exp_wr));
      idle();
      check("basic_one_pulse", 32'(dram_valid), 32'd0);
      check("basic_data_zero", data_rd, 32'd0);

      // Streaming: 8 writes, then 8 back-to-back reads
      for (int i = 0; i < 8; i++) wr(18'(i), 32'h100 + 32'(i));
      for (int i = 0; i < 8; i++) begin
         rd(18'(i));
         if (i > 0) begin
            check("stream_valid", 32'(dram_valid), 32'd1);
            check("stream_data", data_rd, 32'h100 + 32'(i - 1));
         end
      end
      idle();
      check("stream_valid_last", 32'(dram_valid), 32'd1);
      check("stream_data_last", data_rd, 32'h107);
      idle();
      check("stream_end", 32'(dram_valid), 32'd0);
      check("stream_rdcnt", rd_cnt, 32'(exp_rd));

      // Reset with two reads in flight
      rd(18'd0);
      dram_en_rd = 1'b1; addr_in = 18'd1;
      @(posedge clk);
      #1;
      srstn = 1'b0;
      dram_en_rd = 1'b0; addr_in = '0;
      exp_rd = 0; exp_wr = 0;
      #1;
      check("midrst_valid", 32'(dram_valid), 32'd0);
      check("midrst_data", data_rd, 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_rdcnt", rd_cnt, 32'd0);
      check("midrst_wrcnt", wr_cnt, 32'd0);
      @(negedge clk);
      @(negedge clk);
      srstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle();
         check("postrst_novalid", 32'(dram_valid), 32'd0);
      end

      // Collision: same-cycle read and write of address 9
      wr(18'd9, 32'h0000_000A);
      drive(1'b1, 18'd9, 1'b1, 18'd9, 32'h0000_000B);
      idle();
      check("coll_valid", 32'(dram_valid), 32'd1);
      check("coll_data", data_rd, exp_coll);
      rd(18'd9);
      idle();
      check("coll_after", data_rd, 32'h0000_000B);

      // Psum read-modify-write on address 3
      wr(18'd3, 32'h0000_0010);
      rd(18'd3);
      wr(18'd3, 32'h0000_0020);
      check("rmw_valid", 32'(dram_valid), 32'd1);
      check("rmw_data", data_rd, exp_rmw);
      check("rmw_err_clear", 32'(err), 32'd0);

      // Out of range: read 1024, write 2000 (aliased index 976 must be untouched)
      wr(18'd976, 32'h0000_3D0A);
      drive(1'b1, 18'd1024, 1'b1, 18'd2000, 32'hDEAD_BEEF);
      idle();
      check("range_valid", 32'(dram_valid), 32'd1);
      check("range_data", data_rd, 32'd0);
      check("range_err", 32'(err), 32'd1);
      check("range_rdcnt", rd_cnt, 32'(exp_rd));
      check("range_wrcnt", wr_cnt, 32'(exp_wr));
      rd(18'd976);
      idle();
      check("range_alias_data", data_rd, 32'h0000_3D0A);
      repeat (3) idle();
      check("range_err_sticky", 32'(err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dram_resp.md
# dram_resp

Memory-side responder for the layer engines' DRAM request interface. Accepts one read and one write request per cycle, serves reads from an internal word array through a fixed-latency pipeline with a `dram_valid` strobe, and commits writes. It replaces the bench-side DRAM model as synthesizable RTL and sits directly on the port pins of `conv_layer`-style initiators.

## Interface
- `DATA_WIDTH`, 32, word width in bits.
- `ADDR_WIDTH`, 18, word-address width.
- `MEM_DEPTH`, 1024, number of implemented words; addresses ≥ MEM_DEPTH are out of range.
- `RD_LAT`, 2, read latency in cycles; legal range 1..4.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `srstn`  in  1  reset, asynchronous assert, active-low.
- `dram_en_rd`  in  1  read request this cycle.
- `addr_in`  in  ADDR_WIDTH  read address, sampled when dram_en_rd=1.
- `dram_en_wr`  in  1  write request this cycle.
- `addr_out`  in  ADDR_WIDTH  write address, sampled when dram_en_wr=1.
- `data_wr`  in  DATA_WIDTH  write data (initiator's data_out).
- `data_rd`  out  DATA_WIDTH  read data (initiator's data_in).
- `dram_valid`  out  1  data_rd holds a returned read word.
- `err`  out  1  sticky out-of-range access flag.
- `rd_cnt`  out  32  accepted read requests, wraps at 2^32.
- `wr_cnt`  out  32  accepted write requests, wraps at 2^32.

## Operation
- Read pipeline: RD_LAT stages, each holding {valid, addr, data}. Stage 1 loads on every edge with valid=dram_en_rd, addr=addr_in, data=array[addr_in] (pre-write value). Stages shift each cycle; no stall, no backpressure.
- data_rd/dram_valid are driven from the last stage. When last-stage valid=0, data_rd=0.
- Write: when dram_en_wr=1 and addr_out in range, array[addr_out] <= data_wr at the edge. Read and write in the same cycle are both accepted, any addresses.
- Out of range: read returns data 0 with dram_valid=1 and sets err; write is dropped and sets err. err clears only on reset.
- Counters increment by 1 per accepted request, including out-of-range ones.
- Memory array is not reset; contents undefined until written. Reset clears all pipeline valids, data_rd, dram_valid, err, rd_cnt, wr_cnt to 0. Reset mid-operation discards all in-flight reads; no dram_valid for them.

## Timing
- Read issued in cycle t (sampled at edge ending t): dram_valid=1 and data_rd valid in cycle t+RD_LAT, for exactly one cycle per request. Back-to-back reads return back-to-back.
- Write issued in cycle t is visible to reads issued in cycle t+1 and later under all configurations.
- Same-cycle read and write to the same address: see Configuration.
- Reset deassertion: first request accepted at the first rising edge with srstn=1.

## Configuration
- `DRAM_RESP_FWD_EN` defined: write forwarding into the read pipeline. Any in-range write to address A in cycle w updates the data field of every pipeline entry with valid=1 and addr=A (stage-1 entry being loaded in the same cycle included). Returned data equals array content after all writes issued in cycles t..t+RD_LAT-1. Matches the conv psum read-modify-write pattern (read A at t, write A at t+1).
- Undefined: no forwarding. Returned data is the array snapshot before the edge ending cycle t; writes issued in cycles t..t+RD_LAT-1 are not reflected.

## Test plan
- Reset: drive srstn=0 mid-stream with 2 reads in flight -> data_rd=0, dram_valid=0, err=0, counters 0; no valid pulse after release.
- Basic: write 0x0000_1234 to addr 5, then read addr 5 two cycles later (RD_LAT=2) -> dram_valid high exactly in issue+2 cycle, data_rd=0x0000_1234; rd_cnt=1, wr_cnt=1.
- Streaming: write addr 0..7 with value 0x100+addr, then 8 consecutive reads of 0..7 -> 8 consecutive valid cycles, data 0x100..0x107 in order.
- Collision: array[9]=0xA; cycle t read 9 and write 9 with 0xB -> 0xB with FWD_EN, 0xA without.
- Psum RMW: array[3]=0x10; read 3 at t, write 3=0x20 at t+1 (RD_LAT=2) -> returned 0x20 with FWD_EN, 0x10 without.
- Range: read addr 1024 and write addr 2000 -> read returns 0 with dram_valid=1, err=1 and stays 1, array[2000 mod anything] unchanged, rd_cnt and wr_cnt each incremented.
